// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: key-schedule FSM states, round count, Rcon and RotWord helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int AES_ROUNDS = 10;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/engine_inv_key_generator_if.sv
// Key/handshake bundle between the decrypt controller and the inverse key schedule.
// Optional stream port: ENGINE_INV_KEY_STREAM_EN.
interface engine_inv_key_generator_if;
  logic [127:0] key_in;
  logic         engine_start;
  logic         transformer_start;
  logic [127:0] round0_key;
  logic [127:0] round1_key;
  logic [127:0] round2_key;
  logic [127:0] round3_key;
  logic [127:0] round4_key;
  logic [127:0] round5_key;
  logic [127:0] round6_key;
  logic [127:0] round7_key;
  logic [127:0] round8_key;
  logic [127:0] round9_key;
  logic [127:0] round10_key;
`ifdef ENGINE_INV_KEY_STREAM_EN
  logic [127:0] stream_key;
  logic         stream_valid;
`endif

  modport master (
    output key_in, output engine_start,
    input  transformer_start,
    input  round0_key, input round1_key, input round2_key, input round3_key,
    input  round4_key, input round5_key, input round6_key, input round7_key,
    input  round8_key, input round9_key, input round10_key
`ifdef ENGINE_INV_KEY_STREAM_EN
    , input stream_key, input stream_valid
`endif
  );

  modport slave (
    input  key_in, input engine_start,
    output transformer_start,
    output round0_key, output round1_key, output round2_key, output round3_key,
    output round4_key, output round5_key, output round6_key, output round7_key,
    output round8_key, output round9_key, output round10_key
`ifdef ENGINE_INV_KEY_STREAM_EN
    , output stream_key, output stream_valid
`endif
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] sbox_o
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  always_comb begin
    base   = 11'd2047 - {data_i, 3'b000};
    sbox_o = SBOX[base -: 8];
  end

endmodule

// File: rtl/engine_inv_key_generator.sv
// Inverse AES-128 key schedule: captures the round-10 key and walks back to round 0, one round per clock.
// Optional per-round key stream output: ENGINE_INV_KEY_STREAM_EN.
module engine_inv_key_generator
  import aes_pkg::*;
(
  input logic                       clk,
  input logic                       rst_,
  engine_inv_key_generator_if.slave bus
);

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         start_q, start_d;
  logic         ts_q, ts_d;
  logic [127:0] key_q [11];
  logic [127:0] key_d [11];
`ifdef ENGINE_INV_KEY_STREAM_EN
  logic [127:0] stream_key_q, stream_key_d;
  logic         stream_valid_q, stream_valid_d;
`endif

  logic         start_edge;
  logic [3:0]   rnd_m1;
  logic [127:0] cur_key, prev_key;
  logic [31:0]  w0, w1, w2, w3, nw3, rot, sub;

  assign start_edge = bus.engine_start & ~start_q;
  assign rnd_m1     = rnd_q - 4'd1;

  // Undo one forward round: later words first, since new w0 needs new w3.
  assign cur_key = key_q[rnd_q];
  assign {w0, w1, w2, w3} = cur_key;
  assign nw3 = w3 ^ w2;
  assign rot = rot_word(nw3);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot[b*8 +: 8]),
      .sbox_o (sub[b*8 +: 8])
    );
  end

  assign prev_key = {w0 ^ sub ^ {rcon(rnd_q), 24'h0}, w1 ^ w0, w2 ^ w1, nw3};

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    start_d = bus.engine_start;
    ts_d    = ts_q;
    key_d   = key_q;
`ifdef ENGINE_INV_KEY_STREAM_EN
    stream_key_d   = stream_key_q;
    stream_valid_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          key_d[10] = bus.key_in;
          for (int i = 0; i < 10; i++) key_d[i] = '0;
          rnd_d   = 4'(AES_ROUNDS);
          state_d = ST_EXPAND;
`ifdef ENGINE_INV_KEY_STREAM_EN
          stream_key_d   = bus.key_in;
          stream_valid_d = 1'b1;
`endif
        end
      end
      ST_EXPAND: begin
        key_d[rnd_m1] = prev_key;
        rnd_d         = rnd_m1;
`ifdef ENGINE_INV_KEY_STREAM_EN
        stream_key_d   = prev_key;
        stream_valid_d = 1'b1;
`endif
        if (rnd_q == 4'd1) begin
          ts_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.engine_start) begin
          ts_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      start_q <= 1'b0;
      ts_q    <= 1'b0;
      key_q   <= '{default: '0};
`ifdef ENGINE_INV_KEY_STREAM_EN
      stream_key_q   <= '0;
      stream_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      start_q <= start_d;
      ts_q    <= ts_d;
      key_q   <= key_d;
`ifdef ENGINE_INV_KEY_STREAM_EN
      stream_key_q   <= stream_key_d;
      stream_valid_q <= stream_valid_d;
`endif
    end
  end

  assign bus.transformer_start = ts_q;
  assign bus.round0_key  = key_q[0];
  assign bus.round1_key  = key_q[1];
  assign bus.round2_key  = key_q[2];
  assign bus.round3_key  = key_q[3];
  assign bus.round4_key  = key_q[4];
  assign bus.round5_key  = key_q[5];
  assign bus.round6_key  = key_q[6];
  assign bus.round7_key  = key_q[7];
  assign bus.round8_key  = key_q[8];
  assign bus.round9_key  = key_q[9];
  assign bus.round10_key = key_q[10];
`ifdef ENGINE_INV_KEY_STREAM_EN
  assign bus.stream_key   = stream_key_q;
  assign bus.stream_valid = stream_valid_q;
`endif

endmodule

// File: tb/tb_engine_inv_key_generator.sv
// Bench for the inverse key schedule: a forward AES-128 expansion model fills a scoreboard of expected round keys.
module tb_engine_inv_key_generator;

  localparam logic [127:0] FIPS_CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RT_CK    = 128'h2475a2b33475568831e2120013aa5487;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  engine_inv_key_generator_if bus ();

  engine_inv_key_generator dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk   [11];
  logic [127:0] sb_q [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived from GF(2^8) inverse plus affine map, independent of any table.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic fwd_expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = ck;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] get_rk(input int i);
    case (i)
      0:  return bus.round0_key;
      1:  return bus.round1_key;
      2:  return bus.round2_key;
      3:  return bus.round3_key;
      4:  return bus.round4_key;
      5:  return bus.round5_key;
      6:  return bus.round6_key;
      7:  return bus.round7_key;
      8:  return bus.round8_key;
      9:  return bus.round9_key;
      default: return bus.round10_key;
    endcase
  endfunction

  function automatic logic [127:0] all_or();
    logic [127:0] acc = '0;
    for (int i = 0; i <= 10; i++) acc = acc | get_rk(i);
    return acc;
  endfunction

  // Called at a negedge. drop_at <= 10 lowers engine_start after edge N+drop_at.
  task automatic run_expand(input logic [127:0] ck, input int drop_at);
    logic [127:0] e;
    fwd_expand(ck);
    for (int r = 10; r >= 0; r--) sb_q.push_back(exp_rk[r]);
    bus.key_in = exp_rk[10];
    bus.engine_start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("round%0d_key", 10 - k), get_rk(10 - k), e);
      chk($sformatf("ts_at_k%0d", k), {127'h0, bus.transformer_start}, {127'h0, k == 10});
`ifdef ENGINE_INV_KEY_STREAM_EN
      chk($sformatf("stream_valid_k%0d", k), {127'h0, bus.stream_valid}, 128'h1);
      chk($sformatf("stream_key_k%0d", k), bus.stream_key, e);
`endif
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      if (k == drop_at) bus.engine_start = 1'b0;
    end
    @(negedge clk);
    chk("ts_after_done", {127'h0, bus.transformer_start}, {127'h0, drop_at > 10});
    chk("round0_final", bus.round0_key, ck);
`ifdef ENGINE_INV_KEY_STREAM_EN
    chk("stream_valid_after", {127'h0, bus.stream_valid}, 128'h0);
`endif
  endtask

  initial begin
    int hold_bad;
    rst_ = 1'b0;
    bus.engine_start = 1'b0;
    bus.key_in = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("reset_ts", {127'h0, bus.transformer_start}, 128'h0);
    chk("reset_keys", all_or(), 128'h0);
    rst_ = 1'b1;
    @(negedge clk);

    // FIPS-197 schedule
    run_expand(FIPS_CK, 99);
    chk("fips_r10", bus.round10_key, FIPS_R10);
    chk("fips_r9", bus.round9_key, FIPS_R9);
    chk("fips_r1", bus.round1_key, FIPS_R1);
    chk("fips_r0", bus.round0_key, FIPS_CK);

    // Hold engine_start high: no re-expansion
    hold_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.transformer_start !== 1'b1 || bus.round0_key !== FIPS_CK || bus.round10_key !== FIPS_R10)
        hold_bad++;
`ifdef ENGINE_INV_KEY_STREAM_EN
      if (bus.stream_valid !== 1'b0) hold_bad++;
`endif
    end
    chk("hold_stable", 128'(hold_bad), 128'h0);
    bus.engine_start = 1'b0;
    @(negedge clk);
    chk("drop_ts", {127'h0, bus.transformer_start}, 128'h0);
    chk("drop_keep_r0", bus.round0_key, FIPS_CK);
    chk("drop_keep_r9", bus.round9_key, FIPS_R9);

    // Restart with a new key: round trip against the forward model
    run_expand(RT_CK, 99);
    bus.engine_start = 1'b0;
    @(negedge clk);
    chk("rt_ts_fall", {127'h0, bus.transformer_start}, 128'h0);

    // Early drop at cycle 3 of EXPAND
    run_expand(FIPS_CK, 3);
    @(negedge clk);
    chk("early_ts_low", {127'h0, bus.transformer_start}, 128'h0);

    // Mid-run reset at cycle 5 of EXPAND
    fwd_expand(RT_CK);
    bus.key_in = exp_rk[10];
    bus.engine_start = 1'b1;
    repeat (6) @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("mrst_ts", {127'h0, bus.transformer_start}, 128'h0);
    chk("mrst_keys", all_or(), 128'h0);
`ifdef ENGINE_INV_KEY_STREAM_EN
    chk("mrst_stream_key", bus.stream_key, 128'h0);
    chk("mrst_stream_valid", {127'h0, bus.stream_valid}, 128'h0);
`endif
    @(negedge clk);
    rst_ = 1'b1;
    run_expand(FIPS_CK, 99);
    bus.engine_start = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
